ram_arbiter: RTL and testbench

Single-port arbiter for the external 8-bit SRAM, shared by three requesters: video fetch, CPU and a DMA engine (tape/loader). It runs on the 28 MHz master clock next to the CPU clock/contention controller. It sequences fixed-length SRAM cycles with priority video > CPU > DMA, plus a starvation guard for DMA. It exports `cpu_wait`, which is ORed into the CPU clock-stretch (`clkwait`) path so the Z80 holds while its access is pending.

---
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Single-port SRAM arbiter for video, CPU and DMA requesters.
// Fixed 3-cycle accesses (ADDR, STRB, DONE), priority video > CPU > DMA, with DMA starvation guard.
module ram_arbiter #(
    parameter int unsigned AW         = 19,
    parameter int unsigned DMA_STARVE = 15
) (
    input  logic          clk28,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [7:0]    vid_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_wait,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic          dma_ack,
    output logic [7:0]    dma_rdata,
    output logic [AW-1:0] ram_a,
    input  logic [7:0]    ram_d_in,
    output logic [7:0]    ram_d_out,
    output logic          ram_d_oe,
    output logic          ram_oe_n,
    output logic          ram_we_n
);

    localparam int unsigned SW = (DMA_STARVE < 2) ? 1 : $clog2(DMA_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(DMA_STARVE);

    typedef enum logic [1:0] {IDLE, ADDR, STRB, DONE} state_t;
    typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_DMA} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [AW-1:0] addr_d;
    logic [SW-1:0] starve_cnt, starve_d;
    logic          grant;
    logic          capture;

    // Next state, arbitration and latch values; outputs are registered from these.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        addr_d   = ram_a;
        starve_d = starve_cnt;
        grant    = 1'b0;
        capture  = (state_q == STRB) && !we_q;

        case (state_q)
            ADDR: state_d = STRB;
            STRB: state_d = DONE;
            default: begin
                state_d = IDLE;
                grant   = 1'b1;
                if (vid_req) begin
                    owner_d = OWN_VID;
                    addr_d  = vid_addr;
                    we_d    = 1'b0;
                end else if (dma_req && (starve_cnt == STARVE_MAX)) begin
                    owner_d = OWN_DMA;
                    addr_d  = dma_addr;
                    we_d    = dma_we;
                    wdata_d = dma_wdata;
                end else if (cpu_req) begin
                    owner_d = OWN_CPU;
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                end else if (dma_req) begin
                    owner_d = OWN_DMA;
                    addr_d  = dma_addr;
                    we_d    = dma_we;
                    wdata_d = dma_wdata;
                end else begin
                    grant = 1'b0;
                end
                if (grant) state_d = ADDR;
            end
        endcase

        // DMA promotion counter: counts non-DMA grants while DMA waits
        if (!dma_req) begin
            starve_d = '0;
        end else if (grant) begin
            if (owner_d == OWN_DMA)
                starve_d = '0;
            else if (starve_cnt != STARVE_MAX)
                starve_d = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_VID;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            starve_cnt <= '0;
            ram_a      <= '0;
            ram_d_out  <= '0;
            ram_d_oe   <= 1'b0;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_wait   <= 1'b0;
            vid_data   <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            starve_cnt <= starve_d;
            ram_a      <= addr_d;
            if (grant && we_d)
                ram_d_out <= wdata_d;
            ram_d_oe   <= we_d && (state_d != IDLE);
            ram_oe_n   <= !(!we_d && ((state_d == ADDR) || (state_d == STRB)));
            ram_we_n   <= !(we_d && (state_d == STRB));
            vid_ack    <= (state_d == DONE) && (owner_d == OWN_VID);
            cpu_ack    <= (state_d == DONE) && (owner_d == OWN_CPU);
            dma_ack    <= (state_d == DONE) && (owner_d == OWN_DMA);
            cpu_wait   <= cpu_req && !((owner_q == OWN_CPU) && (state_q == DONE));
            // Read data sampled at the end of STRB so it is valid alongside the ack
            if (capture) begin
                case (owner_q)
                    OWN_VID: vid_data  <= ram_d_in;
                    OWN_CPU: cpu_rdata <= ram_d_in;
                    OWN_DMA: dma_rdata <= ram_d_in;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural SRAM model.
module tb_ram_arbiter;

    localparam int unsigned AW = 19;

    logic          clk28 = 1'b0;
    logic          rst;
    logic          vid_req, cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] vid_addr, cpu_addr, dma_addr;
    logic [7:0]    cpu_wdata, dma_wdata;
    logic          vid_ack, cpu_ack, dma_ack, cpu_wait;
    logic [7:0]    vid_data, cpu_rdata, dma_rdata;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d_in, ram_d_out;
    logic          ram_d_oe, ram_oe_n, ram_we_n;

    logic [7:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    ram_arbiter #(.AW(AW), .DMA_STARVE(15)) dut (
        .clk28(clk28), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_a(ram_a), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out),
        .ram_d_oe(ram_d_oe), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    always #5 clk28 = ~clk28;

    assign ram_d_in = mem[ram_a];

    always @(posedge clk28)
        if (!ram_we_n && ram_d_oe) mem[ram_a] <= ram_d_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk28);
        #1;
    endtask

    // Single CPU access; request held until ack, dropped in the ack cycle.
    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        bit seen = 0;
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (cpu_ack) begin
                seen = 1;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        chk("cpu_access_ack_seen", 32'(seen), 32'd1);
        step();
    endtask

    initial begin
        int t_vid, t_cpu, t_dma, n_vid, n_cpu;
        bit got_dma;

        rst = 1'b1;
        vid_req = 0; cpu_req = 0; cpu_we = 0; dma_req = 0; dma_we = 0;
        vid_addr = '0; cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
        mem[19'h14000] = 8'hA5;
        mem[19'h00100] = 8'h11;
        mem[19'h00200] = 8'h22;
        mem[19'h07FFF] = 8'h00;
        mem[19'h00300] = 8'h00;

        // Reset state
        step(); step();
        chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
        chk("rst_we_n", 32'(ram_we_n), 32'd1);
        chk("rst_d_oe", 32'(ram_d_oe), 32'd0);
        chk("rst_acks", {29'd0, vid_ack, cpu_ack, dma_ack}, 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rst_ram_a", 32'(ram_a), 32'd0);
        chk("rst_rdata", {8'd0, vid_data, cpu_rdata, dma_rdata}, 32'd0);
        rst = 1'b0;
        step();

        // CPU read alone
        cpu_we = 0; cpu_addr = 19'h14000; cpu_req = 1'b1;
        step();
        chk("rd_addr_ram_a", 32'(ram_a), 32'h14000);
        chk("rd_addr_oe_n", 32'(ram_oe_n), 32'd0);
        chk("rd_addr_wait", 32'(cpu_wait), 32'd1);
        chk("rd_addr_ack", 32'(cpu_ack), 32'd0);
        step();
        chk("rd_strb_oe_n", 32'(ram_oe_n), 32'd0);
        chk("rd_strb_ack", 32'(cpu_ack), 32'd0);
        chk("rd_strb_wait", 32'(cpu_wait), 32'd1);
        step();
        chk("rd_done_ack", 32'(cpu_ack), 32'd1);
        chk("rd_done_rdata", 32'(cpu_rdata), 32'hA5);
        chk("rd_done_oe_n", 32'(ram_oe_n), 32'd1);
        chk("rd_done_wait", 32'(cpu_wait), 32'd1);
        cpu_req = 1'b0;
        step();
        chk("rd_after_ack", 32'(cpu_ack), 32'd0);
        chk("rd_after_wait", 32'(cpu_wait), 32'd0);
        chk("rd_hold_rdata", 32'(cpu_rdata), 32'hA5);

        // CPU write
        cpu_we = 1; cpu_addr = 19'h07FFF; cpu_wdata = 8'h3C; cpu_req = 1'b1;
        step();
        chk("wr_addr_d_oe", 32'(ram_d_oe), 32'd1);
        chk("wr_addr_we_n", 32'(ram_we_n), 32'd1);
        chk("wr_addr_d_out", 32'(ram_d_out), 32'h3C);
        chk("wr_addr_oe_n", 32'(ram_oe_n), 32'd1);
        step();
        chk("wr_strb_we_n", 32'(ram_we_n), 32'd0);
        chk("wr_strb_d_oe", 32'(ram_d_oe), 32'd1);
        step();
        chk("wr_done_we_n", 32'(ram_we_n), 32'd1);
        chk("wr_done_d_oe", 32'(ram_d_oe), 32'd1);
        chk("wr_done_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        step();
        chk("wr_after_d_oe", 32'(ram_d_oe), 32'd0);
        chk("wr_mem", 32'(mem[19'h07FFF]), 32'h3C);

        // All three requesters in the same cycle
        t_vid = 0; t_cpu = 0; t_dma = 0;
        vid_addr = 19'h00100; vid_req = 1'b1;
        cpu_we = 0; cpu_addr = 19'h00200; cpu_req = 1'b1;
        dma_we = 1; dma_addr = 19'h00300; dma_wdata = 8'h33; dma_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (vid_ack) begin t_vid = c; vid_req = 1'b0; end
            if (cpu_ack) begin t_cpu = c; cpu_req = 1'b0; end
            if (dma_ack) begin t_dma = c; dma_req = 1'b0; end
        end
        vid_req = 0; cpu_req = 0; dma_req = 0;
        chk("all3_vid_ack_cycle", 32'(t_vid), 32'd3);
        chk("all3_cpu_ack_cycle", 32'(t_cpu), 32'd6);
        chk("all3_dma_ack_cycle", 32'(t_dma), 32'd9);
        chk("all3_vid_data", 32'(vid_data), 32'h11);
        chk("all3_cpu_rdata", 32'(cpu_rdata), 32'h22);
        chk("all3_dma_mem", 32'(mem[19'h00300]), 32'h33);

        // Video read data held across a CPU write of different data
        cpu_access(1'b1, 19'h00100, 8'h5A);
        chk("hold_vid_data", 32'(vid_data), 32'h11);
        chk("hold_mem", 32'(mem[19'h00100]), 32'h5A);

        // DMA starvation: 1 video + 14 CPU grants, then DMA ahead of CPU
        n_vid = 0; n_cpu = 0; got_dma = 0;
        vid_addr = 19'h00100; vid_req = 1'b1;
        cpu_we = 0; cpu_addr = 19'h00200; cpu_req = 1'b1;
        dma_we = 0; dma_addr = 19'h14000; dma_req = 1'b1;
        for (int c = 0; c < 120 && !got_dma; c++) begin
            step();
            if (vid_ack) begin n_vid++; vid_req = 1'b0; end
            if (cpu_ack) n_cpu++;
            if (dma_ack) begin
                got_dma = 1;
                chk("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
                chk("starve_dma_rdata", 32'(dma_rdata), 32'hA5);
                dma_req = 1'b0;
                cpu_req = 1'b0;
            end
        end
        vid_req = 0; cpu_req = 0; dma_req = 0;
        chk("starve_dma_granted", 32'(got_dma), 32'd1);
        chk("starve_vid_grants", 32'(n_vid), 32'd1);
        chk("starve_cpu_grants", 32'(n_cpu), 32'd14);
        step(); step();

        // Reset asserted during a CPU write strobe
        cpu_we = 1; cpu_addr = 19'h00050; cpu_wdata = 8'h77; cpu_req = 1'b1;
        step();
        step();
        chk("rstwr_strb_we_n", 32'(ram_we_n), 32'd0);
        rst = 1'b1;
        step();
        chk("rstwr_we_n", 32'(ram_we_n), 32'd1);
        chk("rstwr_d_oe", 32'(ram_d_oe), 32'd0);
        chk("rstwr_ack", 32'(cpu_ack), 32'd0);
        rst = 1'b0;
        cpu_req = 1'b0;
        step();
        chk("rstwr_no_ack1", 32'(cpu_ack), 32'd0);
        step();
        chk("rstwr_no_ack2", 32'(cpu_ack), 32'd0);
        chk("rstwr_idle_oe_n", 32'(ram_oe_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
